// File: rtl/riscv_mem_stage_if.sv
// rtl/riscv_mem_stage_if.sv - data-memory request bus between the memory stage and the memory system
interface riscv_mem_stage_if #(
  parameter int XLEN = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_adr;
  logic [1:0]        dmem_size;
  logic [XLEN/8-1:0] dmem_be;
  logic [XLEN-1:0]   dmem_d;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_adr, dmem_size, dmem_be, dmem_d,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_adr, dmem_size, dmem_be, dmem_d,
    output dmem_ack
  );
endinterface

// File: rtl/riscv_mem_stage.sv
// rtl/riscv_mem_stage.sv - memory-access pipeline stage: registers execute results and issues
// one lane-aligned data-memory request per load/store, held until acknowledged
module riscv_mem_stage #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] PC_INIT        = 'h200,
  parameter int              ILEN           = 32,
  parameter int              EXCEPTION_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_stall,
  output logic                      mem_stall,
  input  logic                      ex_flush,
  input  logic [XLEN-1:0]           ex_pc,
  input  logic [ILEN-1:0]           ex_instr,
  input  logic                      ex_bubble,
  input  logic [EXCEPTION_SIZE-1:0] ex_exception,
  input  logic [XLEN-1:0]           ex_r,
  input  logic [XLEN-1:0]           ex_memadr,
  input  logic [XLEN-1:0]           ex_wdata,
  output logic [XLEN-1:0]           mem_pc,
  output logic [ILEN-1:0]           mem_instr,
  output logic                      mem_bubble,
  output logic [EXCEPTION_SIZE-1:0] mem_exception,
  output logic [XLEN-1:0]           mem_r,
  output logic [XLEN-1:0]           mem_memadr,
  riscv_mem_stage_if.master         dmem
);
  localparam int             BW        = XLEN / 8;
  localparam int             AW        = (XLEN == 64) ? 3 : 2;
  localparam logic [ILEN-1:0] INSTR_NOP = ILEN'(32'h0000_0013);
  localparam logic [4:0]     OPC_LOAD  = 5'b00000;
  localparam logic [4:0]     OPC_STORE = 5'b01000;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic            cap, kill, is_store, cap_mem, load_req, clr_req;
  logic [4:0]      opc;
  logic [AW-1:0]   lane;
  logic [BW-1:0]   new_be;
  logic [XLEN-1:0] new_d;
  logic            req_we;
  logic [XLEN-1:0] req_adr;
  logic [1:0]      req_size;
  logic [BW-1:0]   req_be;
  logic [XLEN-1:0] req_d;

  assign mem_stall = wb_stall;
  assign cap       = !wb_stall;
  assign kill      = ex_flush | ex_bubble;
  assign opc       = ex_instr[6:2];
  assign is_store  = (opc == OPC_STORE);
  assign cap_mem   = cap && !kill && (ex_exception == '0) && ((opc == OPC_LOAD) || is_store);
  assign lane      = ex_memadr[AW-1:0];

  // Store data is replicated across every lane so the memory only needs the byte enables.
  always_comb begin
    new_be = '0;
    new_d  = '0;
    unique case (ex_instr[13:12])
      2'd0: begin
        new_be = BW'(1) << lane;
        new_d  = {BW{ex_wdata[7:0]}};
      end
      2'd1: begin
        new_be = BW'(3) << lane;
        new_d  = {(XLEN/16){ex_wdata[15:0]}};
      end
      2'd2: begin
        new_be = BW'(15) << lane;
        new_d  = {(XLEN/32){ex_wdata[31:0]}};
      end
      default: begin
        if (XLEN == 64) begin
          new_be = '1;
          new_d  = ex_wdata;
        end else begin
          new_be = BW'(15) << lane;
          new_d  = {(XLEN/32){ex_wdata[31:0]}};
        end
      end
    endcase
    if (!is_store) new_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    clr_req    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cap_mem) begin
          load_req   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          if (cap_mem) begin
            load_req = 1'b1;
          end else begin
            clr_req    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_we   <= 1'b0;
      req_adr  <= '0;
      req_size <= 2'd0;
      req_be   <= '0;
      req_d    <= '0;
    end else if (load_req) begin
      req_we   <= is_store;
      req_adr  <= ex_memadr;
      req_size <= ex_instr[13:12];
      req_be   <= new_be;
      req_d    <= new_d;
    end else if (clr_req) begin
      req_we   <= 1'b0;
      req_size <= 2'd0;
      req_be   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_pc        <= PC_INIT;
      mem_instr     <= INSTR_NOP;
      mem_bubble    <= 1'b1;
      mem_exception <= '0;
      mem_r         <= '0;
      mem_memadr    <= '0;
    end else if (cap) begin
      mem_pc     <= ex_pc;
      mem_r      <= ex_r;
      mem_memadr <= ex_memadr;
      if (kill) begin
        mem_bubble    <= 1'b1;
        mem_instr     <= INSTR_NOP;
        mem_exception <= '0;
      end else begin
        mem_bubble    <= 1'b0;
        mem_instr     <= ex_instr;
        mem_exception <= ex_exception;
      end
    end
  end

  assign dmem.dmem_req  = (state == BUSY);
  assign dmem.dmem_we   = req_we;
  assign dmem.dmem_adr  = req_adr;
  assign dmem.dmem_size = req_size;
  assign dmem.dmem_be   = req_be;
  assign dmem.dmem_d    = req_d;
endmodule
